// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences kernel+image words from memory into a convolution engine and stores its results.
// Define CONV_SEQ_TIMEOUT_EN to abort DRAIN with err after TMO cycles without eng_end_conv.
module conv_seq_ctrl #(
  parameter int N   = 3,
  parameter int M   = 2,
  parameter int AW  = 8,
  parameter int TMO = 64
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] kbase,
  input  logic [AW-1:0] ibase,
  input  logic [AW-1:0] rbase,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          eng_rst,
  output logic [31:0]   eng_a_in,
  input  logic [31:0]   eng_result,
  input  logic          eng_out_valid,
  input  logic          eng_end_conv,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [31:0]   res_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [5:0]    res_cnt
);
  localparam int MM = M * M;
  localparam int W  = MM + N * N;
  localparam int RD = N - M + 1;
  localparam int R  = RD * RD;
  localparam int FW = $clog2(W + 1);
  typedef enum logic [2:0] {IDLE, RSTE, FEED, DRAIN, FIN} state_t;
  state_t        r_state, w_next;
  logic [AW-1:0] r_kbase, r_ibase, r_rbase;
  logic [FW-1:0] r_f, w_nidx;
  logic [5:0]    r_cnt;
  logic          r_err;
  logic          w_act, w_full, w_wr, w_ovf, w_last, w_addr_ok, w_tmo;
  assign w_act     = (r_state == FEED) || (r_state == DRAIN);
  assign w_full    = r_cnt == 6'(R);
  assign w_wr      = w_act && eng_out_valid && !w_full;
  assign w_ovf     = w_act && eng_out_valid && w_full;
  assign w_last    = r_f == FW'(W - 1);
  // mem_addr runs one word ahead of eng_a_in to cover the 1-cycle read latency
  assign w_nidx    = (r_state == RSTE) ? '0 : r_f + FW'(1);
  assign w_addr_ok = (r_state == RSTE) || ((r_state == FEED) && !w_last);
  assign mem_addr  = !w_addr_ok ? '0 :
                     (w_nidx < FW'(MM)) ? r_kbase + AW'(w_nidx) : r_ibase + AW'(w_nidx - FW'(MM));
  assign eng_rst   = (r_state == IDLE) || (r_state == RSTE);
  assign eng_a_in  = (r_state == FEED) ? mem_rdata : '0;
  assign res_we    = w_wr;
  assign res_addr  = w_wr ? r_rbase + AW'(r_cnt) : '0;
  assign res_data  = w_wr ? eng_result : '0;
  assign busy      = r_state != IDLE;
  assign done      = r_state == FIN;
  assign err       = (r_state != IDLE) && (r_err || ((r_state == FIN) && !w_full));
  assign res_cnt   = (r_state == IDLE) ? '0 : r_cnt;
`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] r_tmo;
  always_ff @(posedge clock or posedge rst)
    if (rst) r_tmo <= '0;
    else r_tmo <= (r_state == DRAIN) ? r_tmo + TW'(1) : '0;
  assign w_tmo = (r_state == DRAIN) && (r_tmo == TW'(TMO - 1));
`else
  assign w_tmo = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RSTE : IDLE;
      RSTE:    w_next = FEED;
      FEED:    w_next = eng_end_conv ? FIN : w_last ? DRAIN : FEED;
      DRAIN:   w_next = (eng_end_conv || w_tmo) ? FIN : DRAIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_kbase <= '0;
      r_ibase <= '0;
      r_rbase <= '0;
      r_f     <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && start) begin
        r_kbase <= kbase;
        r_ibase <= ibase;
        r_rbase <= rbase;
        r_f     <= '0;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end
      if ((r_state == FEED) && !w_last) r_f <= r_f + FW'(1);
      if (w_wr) r_cnt <= r_cnt + 6'd1;
      if (w_ovf || (w_tmo && !eng_end_conv)) r_err <= 1'b1;
    end
endmodule
